// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle controller: state codes, ALU operations,
// opcode classes, datapath select values and trap causes.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    ST_FETCH    = 4'd0,
    ST_DECODE   = 4'd1,
    ST_EXEC_R   = 4'd2,
    ST_WB_R     = 4'd3,
    ST_EXEC_I   = 4'd4,
    ST_WB_I     = 4'd5,
    ST_MEM_ADDR = 4'd6,
    ST_MEM_RD   = 4'd7,
    ST_MEM_WB   = 4'd8,
    ST_MEM_WR   = 4'd9,
    ST_BRANCH   = 4'd10,
    ST_JUMP     = 4'd11,
    ST_JAL      = 4'd12,
    ST_TRAP_OPC = 4'd13,
    ST_TRAP_MEM = 4'd14
  } state_t;

  localparam logic [2:0] ALU_AND    = 3'b000;
  localparam logic [2:0] ALU_OR     = 3'b001;
  localparam logic [2:0] ALU_ADD    = 3'b010;
  localparam logic [2:0] ALU_CMP_EQ = 3'b011;
  localparam logic [2:0] ALU_XOR    = 3'b100;
  localparam logic [2:0] ALU_CMP_LT = 3'b111;

  localparam logic [1:0] CLS_JUMP    = 2'b00;
  localparam logic [1:0] CLS_RTYPE   = 2'b01;
  localparam logic [1:0] CLS_BRANCH  = 2'b10;
  localparam logic [1:0] CLS_IMM_MEM = 2'b11;
  localparam logic [2:0] MEM_OP_LW   = 3'b101;
  localparam logic [2:0] MEM_OP_SW   = 3'b110;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam logic [2:0] SRCA_PC  = 3'b000;
  localparam logic [2:0] SRCA_REG = 3'b001;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;

  localparam logic [1:0] REGDST_RA  = 2'b10;
  localparam logic [1:0] ZORS_SIGN  = 2'b00;
  localparam logic [1:0] ZORS_ZERO  = 2'b01;

  localparam logic [1:0] TRAP_NONE    = 2'b00;
  localparam logic [1:0] TRAP_ILLEGAL = 2'b01;
  localparam logic [1:0] TRAP_TIMEOUT = 2'b10;

  // Where DECODE goes for the low six opcode bits; ST_TRAP_OPC marks illegal.
  function automatic state_t decode_target(input logic [5:0] op);
    state_t t;
    t = ST_TRAP_OPC;
    case (op[5:4])
      CLS_JUMP: begin
        if (op[3:0] == 4'b0000)  t = ST_FETCH;
        else if (op[1:0] == 2'b11) t = ST_JAL;
        else                     t = ST_JUMP;
      end
      CLS_RTYPE:  t = ST_EXEC_R;
      CLS_BRANCH: t = (op[3:2] == 2'b00) ? ST_BRANCH : ST_TRAP_OPC;
      default: begin
        if (!op[3])                                      t = ST_EXEC_I;
        else if (op[2:0] == MEM_OP_LW || op[2:0] == MEM_OP_SW) t = ST_MEM_ADDR;
        else                                             t = ST_TRAP_OPC;
      end
    endcase
    return t;
  endfunction

  // ORI/ANDI/XORI zero-extend their immediate.
  function automatic logic is_logical_imm(input logic [2:0] aop);
    return (aop == ALU_AND) || (aop == ALU_OR) || (aop == ALU_XOR);
  endfunction

endpackage

// File: rtl/mc_control_fsm_if.sv
// Controller-to-datapath bundle: opcode and memory handshake in, every select
// and enable out, plus trap status and a state debug tap.
interface mc_control_fsm_if #(parameter int OPCODE_W = 6);
  // Handshake: MemReq is held high by the controller for the whole access;
  // the access completes in the cycle MemReady is sampled high while MemReq is high.
  logic [OPCODE_W-1:0] Opcode;
  logic                MemReady;
  logic                MemReq;
  logic [2:0]          ALUOp;
  logic [2:0]          ALUSrcA;
  logic [1:0]          PCSource;
  logic [1:0]          ALUSrcB;
  logic [1:0]          BorN;
  logic [1:0]          ZorS;
  logic [1:0]          RegDst;
  logic                PCWrite;
  logic                PCWriteCond;
  logic                RegWrite;
  logic                IRWrite;
  logic                MemWrite;
  logic                MemToReg;
  logic                Read1or3;
  logic                Trap;
  logic [1:0]          TrapCause;
  logic [3:0]          StateDbg;

  modport master (
    input  Opcode, MemReady,
    output MemReq, ALUOp, ALUSrcA, PCSource, ALUSrcB, BorN, ZorS, RegDst,
           PCWrite, PCWriteCond, RegWrite, IRWrite, MemWrite, MemToReg,
           Read1or3, Trap, TrapCause, StateDbg
  );

  modport slave (
    output Opcode, MemReady,
    input  MemReq, ALUOp, ALUSrcA, PCSource, ALUSrcB, BorN, ZorS, RegDst,
           PCWrite, PCWriteCond, RegWrite, IRWrite, MemWrite, MemToReg,
           Read1or3, Trap, TrapCause, StateDbg
  );
endinterface

// File: rtl/mc_wait_timer.sv
// Memory wait-state counter: counts stalled request cycles and flags the
// cycle in which the stall reaches TIMEOUT without completion.
module mc_wait_timer #(
  parameter int TIMEOUT = 15
) (
  input  logic CLK,
  input  logic Reset,
  input  logic req,
  input  logic ready,
  output logic timeout
);
  localparam logic [7:0] LIMIT = 8'(TIMEOUT);

  logic [7:0] count;

  // A completed access always leaves its request state, so clearing on
  // completion or outside a request state also clears on every entry.
  always_ff @(posedge CLK) begin
    if (Reset || !req || ready) count <= '0;
    else if (count != LIMIT)    count <= count + 8'd1;
  end

  assign timeout = req && !ready && (count == LIMIT);
endmodule

// File: rtl/mc_control_fsm.sv
// Multi-cycle MIPS-style control FSM with variable-latency memory handshake.
// Define MC_CTRL_TRAP_EN to enable illegal-opcode/timeout traps and the TRAP states.
module mc_control_fsm #(
  parameter int OPCODE_W = 6,
  parameter int TIMEOUT  = 15
) (
  input logic               CLK,
  input logic               Reset,
  mc_control_fsm_if.master  bus
);
  import mc_ctrl_pkg::*;

`ifdef MC_CTRL_TRAP_EN
  localparam state_t ILLEGAL_DEST = ST_TRAP_OPC;
`else
  localparam state_t ILLEGAL_DEST = ST_FETCH;
`endif

  state_t     state, state_next, target;
  logic [5:0] op;
  logic       upper_zero, legal, req, timeout;
  logic       trap_c;
  logic [1:0] cause_c;

  assign op = bus.Opcode[5:0];

  generate
    if (OPCODE_W > 6) begin : g_wide
      assign upper_zero = ~|bus.Opcode[OPCODE_W-1:6];
    end else begin : g_narrow
      assign upper_zero = 1'b1;
    end
  endgenerate

  assign target = decode_target(op);
  assign legal  = upper_zero && (target != ST_TRAP_OPC);
  assign req    = (state == ST_FETCH) || (state == ST_MEM_RD) || (state == ST_MEM_WR);

`ifdef MC_CTRL_TRAP_EN
  mc_wait_timer #(.TIMEOUT(TIMEOUT)) u_wait_timer (
    .CLK     (CLK),
    .Reset   (Reset),
    .req     (req),
    .ready   (bus.MemReady),
    .timeout (timeout)
  );
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (Reset) state <= ST_FETCH;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_FETCH: begin
        if (bus.MemReady)  state_next = ST_DECODE;
        else if (timeout)  state_next = ST_TRAP_MEM;
      end
      ST_DECODE:   state_next = legal ? target : ILLEGAL_DEST;
      ST_EXEC_R:   state_next = ST_WB_R;
      ST_EXEC_I:   state_next = ST_WB_I;
      ST_MEM_ADDR: state_next = (op[2:0] == MEM_OP_SW) ? ST_MEM_WR : ST_MEM_RD;
      ST_MEM_RD: begin
        if (bus.MemReady)  state_next = ST_MEM_WB;
        else if (timeout)  state_next = ST_TRAP_MEM;
      end
      ST_MEM_WR: begin
        if (bus.MemReady)  state_next = ST_FETCH;
        else if (timeout)  state_next = ST_TRAP_MEM;
      end
      ST_TRAP_OPC, ST_TRAP_MEM: state_next = state;
      default: state_next = ST_FETCH;
    endcase
  end

  // Outputs are forced to zero for the whole time Reset is high.
  always_comb begin
    bus.MemReq      = 1'b0;
    bus.ALUOp       = 3'b000;
    bus.ALUSrcA     = SRCA_PC;
    bus.PCSource    = PCSRC_ALU;
    bus.ALUSrcB     = SRCB_REG;
    bus.BorN        = 2'b00;
    bus.ZorS        = ZORS_SIGN;
    bus.RegDst      = 2'b00;
    bus.PCWrite     = 1'b0;
    bus.PCWriteCond = 1'b0;
    bus.RegWrite    = 1'b0;
    bus.IRWrite     = 1'b0;
    bus.MemWrite    = 1'b0;
    bus.MemToReg    = 1'b0;
    bus.Read1or3    = 1'b0;
    trap_c          = 1'b0;
    cause_c         = TRAP_NONE;
    if (!Reset) begin
      case (state)
        ST_FETCH: begin
          bus.MemReq  = 1'b1;
          bus.ALUSrcB = SRCB_FOUR;
          bus.ALUOp   = ALU_ADD;
          bus.IRWrite = bus.MemReady;
          bus.PCWrite = bus.MemReady;
        end
        ST_DECODE: begin
          bus.ALUSrcB  = SRCB_IMM;
          bus.ALUOp    = ALU_ADD;
          bus.Read1or3 = (op[5:4] == CLS_RTYPE);
        end
        ST_EXEC_R: begin
          bus.ALUSrcA = SRCA_REG;
          bus.ALUSrcB = SRCB_REG;
          bus.ALUOp   = op[2:0];
        end
        ST_EXEC_I: begin
          bus.ALUSrcA = SRCA_REG;
          bus.ALUSrcB = SRCB_IMM;
          bus.ALUOp   = op[2:0];
          bus.ZorS    = is_logical_imm(op[2:0]) ? ZORS_ZERO : ZORS_SIGN;
        end
        ST_WB_R, ST_WB_I: bus.RegWrite = 1'b1;
        ST_MEM_ADDR: begin
          bus.ALUSrcA = SRCA_REG;
          bus.ALUSrcB = SRCB_IMM;
          bus.ALUOp   = ALU_ADD;
        end
        ST_MEM_RD: bus.MemReq = 1'b1;
        ST_MEM_WB: begin
          bus.RegWrite = 1'b1;
          bus.MemToReg = 1'b1;
        end
        ST_MEM_WR: begin
          bus.MemReq   = 1'b1;
          bus.MemWrite = 1'b1;
        end
        ST_BRANCH: begin
          bus.ALUSrcA     = SRCA_REG;
          bus.ALUOp       = op[1] ? ALU_CMP_LT : ALU_CMP_EQ;
          bus.BorN        = op[1:0];
          bus.PCSource    = PCSRC_ALUOUT;
          bus.PCWriteCond = 1'b1;
        end
        ST_JUMP: begin
          bus.PCSource = PCSRC_JUMP;
          bus.PCWrite  = 1'b1;
        end
        ST_JAL: begin
          bus.PCSource = PCSRC_JUMP;
          bus.PCWrite  = 1'b1;
          bus.RegDst   = REGDST_RA;
          bus.RegWrite = 1'b1;
        end
        ST_TRAP_OPC: begin
          trap_c  = 1'b1;
          cause_c = TRAP_ILLEGAL;
        end
        ST_TRAP_MEM: begin
          trap_c  = 1'b1;
          cause_c = TRAP_TIMEOUT;
        end
        default: ;
      endcase
    end
  end

`ifdef MC_CTRL_TRAP_EN
  assign bus.Trap      = trap_c;
  assign bus.TrapCause = cause_c;
`else
  assign bus.Trap      = 1'b0;
  assign bus.TrapCause = 2'b00;
`endif

  assign bus.StateDbg = Reset ? 4'd0 : state;
endmodule

// File: tb/tb_mc_control_fsm.sv
// Self-checking bench for mc_control_fsm: instruction table plus hand-written
// trap, timeout-boundary and reset-abort sequences; handles both macro builds.
module tb_mc_control_fsm;
  import mc_ctrl_pkg::*;

  localparam int TMO = 4;

  logic clk;
  logic rst;

  mc_control_fsm_if #(.OPCODE_W(6)) bus();

  mc_control_fsm #(.OPCODE_W(6), .TIMEOUT(TMO)) dut (
    .CLK   (clk),
    .Reset (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [5:0] op;
    int         fw;
    int         mw;
    int         n;
    state_t     seq [5];
  } vec_t;

  vec_t        vecs [$];
  logic [30:0] exp_q [$];
  int          n_vec = 0;
  int          n_err = 0;

  function automatic logic [30:0] pack(
    input logic [3:0] sd, input logic mr, input logic [2:0] aop, input logic [2:0] sa,
    input logic [1:0] pcs, input logic [1:0] sb, input logic [1:0] bn, input logic [1:0] zs,
    input logic [1:0] rd, input logic pw, input logic pwc, input logic rw, input logic irw,
    input logic mw, input logic m2r, input logic r13, input logic tr, input logic [1:0] tc);
    return {sd, mr, aop, sa, pcs, sb, bn, zs, rd, pw, pwc, rw, irw, mw, m2r, r13, tr, tc};
  endfunction

  function automatic logic [30:0] dut_word();
    return pack(bus.StateDbg, bus.MemReq, bus.ALUOp, bus.ALUSrcA, bus.PCSource, bus.ALUSrcB,
                bus.BorN, bus.ZorS, bus.RegDst, bus.PCWrite, bus.PCWriteCond, bus.RegWrite,
                bus.IRWrite, bus.MemWrite, bus.MemToReg, bus.Read1or3, bus.Trap, bus.TrapCause);
  endfunction

  // Expected control word for a state, written from the controller's output table.
  function automatic logic [30:0] model(input logic r, input state_t st,
                                        input logic [5:0] op, input logic rdy);
    logic       mr, pw, pwc, rw, irw, mw, m2r, r13, tr;
    logic [2:0] aop, sa;
    logic [1:0] pcs, sb, bn, zs, rd, tc;
    {mr, pw, pwc, rw, irw, mw, m2r, r13, tr} = '0;
    {aop, sa} = '0;
    {pcs, sb, bn, zs, rd, tc} = '0;
    if (r) return '0;
    case (st)
      ST_FETCH:    begin mr = 1; sb = 2'b01; aop = 3'b010; irw = rdy; pw = rdy; end
      ST_DECODE:   begin sb = 2'b10; aop = 3'b010; r13 = (op[5:4] == 2'b01); end
      ST_EXEC_R:   begin sa = 3'b001; aop = op[2:0]; end
      ST_EXEC_I:   begin
        sa = 3'b001; sb = 2'b10; aop = op[2:0];
        zs = (op[2:0] == 3'b000 || op[2:0] == 3'b001 || op[2:0] == 3'b100) ? 2'b01 : 2'b00;
      end
      ST_WB_R, ST_WB_I: rw = 1;
      ST_MEM_ADDR: begin sa = 3'b001; sb = 2'b10; aop = 3'b010; end
      ST_MEM_RD:   mr = 1;
      ST_MEM_WB:   begin rw = 1; m2r = 1; end
      ST_MEM_WR:   begin mr = 1; mw = 1; end
      ST_BRANCH:   begin sa = 3'b001; aop = op[1] ? 3'b111 : 3'b011; bn = op[1:0]; pcs = 2'b01; pwc = 1; end
      ST_JUMP:     begin pcs = 2'b10; pw = 1; end
      ST_JAL:      begin pcs = 2'b10; pw = 1; rd = 2'b10; rw = 1; end
      ST_TRAP_OPC: begin tr = 1; tc = 2'b01; end
      ST_TRAP_MEM: begin tr = 1; tc = 2'b10; end
      default: ;
    endcase
    return pack(st, mr, aop, sa, pcs, sb, bn, zs, rd, pw, pwc, rw, irw, mw, m2r, r13, tr, tc);
  endfunction

  task automatic drive_cycle(input string name, input logic r, input logic [5:0] op,
                             input logic rdy, input state_t st);
    logic [30:0] got, exp;
    @(negedge clk);
    rst          = r;
    bus.Opcode   = op;
    bus.MemReady = rdy;
    exp_q.push_back(model(r, st, op, rdy));
    #1;
    got = dut_word();
    exp = exp_q.pop_front();
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: state %0d got word %h expected %h", name, st, got, exp);
    end
  endtask

  task automatic add_vec(input string name, input logic [5:0] op, input int fw, input int mw,
                         input int n, input state_t s0, input state_t s1, input state_t s2,
                         input state_t s3, input state_t s4);
    vec_t v;
    v.name = name; v.op = op; v.fw = fw; v.mw = mw; v.n = n;
    v.seq[0] = s0; v.seq[1] = s1; v.seq[2] = s2; v.seq[3] = s3; v.seq[4] = s4;
    vecs.push_back(v);
  endtask

  // Request states get fw/mw stalled cycles then a ready cycle; elsewhere MemReady is random.
  task automatic run_vec(input vec_t v);
    int waits;
    for (int i = 0; i < v.n; i++) begin
      if (v.seq[i] == ST_FETCH) waits = v.fw;
      else if (v.seq[i] == ST_MEM_RD || v.seq[i] == ST_MEM_WR) waits = v.mw;
      else waits = -1;
      if (waits >= 0) begin
        for (int w = 0; w < waits; w++) drive_cycle(v.name, 1'b0, v.op, 1'b0, v.seq[i]);
        drive_cycle(v.name, 1'b0, v.op, 1'b1, v.seq[i]);
      end else begin
        drive_cycle(v.name, 1'b0, v.op, 1'($urandom_range(0, 1)), v.seq[i]);
      end
    end
  endtask

  initial begin
    rst          = 1'b1;
    bus.Opcode   = '0;
    bus.MemReady = 1'b0;
    repeat (2) @(posedge clk);
    drive_cycle("reset", 1'b1, 6'b010010, 1'b1, ST_FETCH);
    drive_cycle("reset", 1'b1, 6'b111101, 1'b0, ST_FETCH);

    add_vec("add",        6'b010010, 0,   0,   4, ST_FETCH, ST_DECODE, ST_EXEC_R,   ST_WB_R,   ST_FETCH);
    add_vec("add_fw2",    6'b010010, 2,   0,   4, ST_FETCH, ST_DECODE, ST_EXEC_R,   ST_WB_R,   ST_FETCH);
    add_vec("r_op110",    6'b010110, 0,   0,   4, ST_FETCH, ST_DECODE, ST_EXEC_R,   ST_WB_R,   ST_FETCH);
    add_vec("lw_w3",      6'b111101, 0,   3,   5, ST_FETCH, ST_DECODE, ST_MEM_ADDR, ST_MEM_RD, ST_MEM_WB);
    add_vec("lw",         6'b111101, 0,   0,   5, ST_FETCH, ST_DECODE, ST_MEM_ADDR, ST_MEM_RD, ST_MEM_WB);
    add_vec("sw",         6'b111110, 0,   0,   4, ST_FETCH, ST_DECODE, ST_MEM_ADDR, ST_MEM_WR, ST_FETCH);
    add_vec("sw_w1",      6'b111110, 1,   1,   4, ST_FETCH, ST_DECODE, ST_MEM_ADDR, ST_MEM_WR, ST_FETCH);
    add_vec("sw_edge",    6'b111110, 0,   TMO, 4, ST_FETCH, ST_DECODE, ST_MEM_ADDR, ST_MEM_WR, ST_FETCH);
    add_vec("lw_edge",    6'b111101, 0,   TMO, 5, ST_FETCH, ST_DECODE, ST_MEM_ADDR, ST_MEM_RD, ST_MEM_WB);
    add_vec("fetch_edge", 6'b010010, TMO, 0,   4, ST_FETCH, ST_DECODE, ST_EXEC_R,   ST_WB_R,   ST_FETCH);
    add_vec("ori",        6'b110001, 0,   0,   4, ST_FETCH, ST_DECODE, ST_EXEC_I,   ST_WB_I,   ST_FETCH);
    add_vec("addi",       6'b110010, 0,   0,   4, ST_FETCH, ST_DECODE, ST_EXEC_I,   ST_WB_I,   ST_FETCH);
    add_vec("xori",       6'b110100, 0,   0,   4, ST_FETCH, ST_DECODE, ST_EXEC_I,   ST_WB_I,   ST_FETCH);
    add_vec("beq",        6'b100000, 0,   0,   3, ST_FETCH, ST_DECODE, ST_BRANCH,   ST_FETCH,  ST_FETCH);
    add_vec("blt",        6'b100010, 0,   0,   3, ST_FETCH, ST_DECODE, ST_BRANCH,   ST_FETCH,  ST_FETCH);
    add_vec("ble",        6'b100011, 0,   0,   3, ST_FETCH, ST_DECODE, ST_BRANCH,   ST_FETCH,  ST_FETCH);
    add_vec("j",          6'b000001, 0,   0,   3, ST_FETCH, ST_DECODE, ST_JUMP,     ST_FETCH,  ST_FETCH);
    add_vec("jal",        6'b000011, 0,   0,   3, ST_FETCH, ST_DECODE, ST_JAL,      ST_FETCH,  ST_FETCH);
    add_vec("noop",       6'b000000, 0,   0,   2, ST_FETCH, ST_DECODE, ST_FETCH,    ST_FETCH,  ST_FETCH);
`ifndef MC_CTRL_TRAP_EN
    add_vec("ill_br_noop",  6'b101100, 0, 0,  2, ST_FETCH, ST_DECODE, ST_FETCH,    ST_FETCH,  ST_FETCH);
    add_vec("ill_mem_noop", 6'b111000, 0, 0,  2, ST_FETCH, ST_DECODE, ST_FETCH,    ST_FETCH,  ST_FETCH);
    add_vec("sw_no_tmo",    6'b111110, 0, 30, 4, ST_FETCH, ST_DECODE, ST_MEM_ADDR, ST_MEM_WR, ST_FETCH);
    add_vec("fetch_no_tmo", 6'b000000, 20, 0, 2, ST_FETCH, ST_DECODE, ST_FETCH,    ST_FETCH,  ST_FETCH);
`endif

    foreach (vecs[k]) run_vec(vecs[k]);

    // Reset in the middle of a stalled load aborts straight back to FETCH.
    drive_cycle("rst_mid_rd", 1'b0, 6'b111101, 1'b1, ST_FETCH);
    drive_cycle("rst_mid_rd", 1'b0, 6'b111101, 1'b0, ST_DECODE);
    drive_cycle("rst_mid_rd", 1'b0, 6'b111101, 1'b0, ST_MEM_ADDR);
    drive_cycle("rst_mid_rd", 1'b0, 6'b111101, 1'b0, ST_MEM_RD);
    drive_cycle("rst_mid_rd", 1'b0, 6'b111101, 1'b0, ST_MEM_RD);
    drive_cycle("rst_mid_rd", 1'b1, 6'b111101, 1'b1, ST_FETCH);
    drive_cycle("after_rst",  1'b0, 6'b111101, 1'b0, ST_FETCH);
    drive_cycle("after_rst",  1'b0, 6'b111101, 1'b1, ST_FETCH);
    drive_cycle("after_rst",  1'b0, 6'b111101, 1'b1, ST_DECODE);

`ifdef MC_CTRL_TRAP_EN
    // Finish the load above, then an illegal branch opcode traps with cause 01.
    drive_cycle("after_rst",  1'b0, 6'b111101, 1'b1, ST_MEM_ADDR);
    drive_cycle("after_rst",  1'b0, 6'b111101, 1'b1, ST_MEM_RD);
    drive_cycle("after_rst",  1'b0, 6'b111101, 1'b1, ST_MEM_WB);
    drive_cycle("illegal_br", 1'b0, 6'b101100, 1'b1, ST_FETCH);
    drive_cycle("illegal_br", 1'b0, 6'b101100, 1'b1, ST_DECODE);
    for (int i = 0; i < 3; i++)
      drive_cycle("illegal_br", 1'b0, 6'b101100, 1'($urandom_range(0, 1)), ST_TRAP_OPC);
    drive_cycle("trap_reset", 1'b1, 6'b101100, 1'b1, ST_FETCH);

    // Store that never completes: TRAP after TMO+1 MEM_WR cycles, cause 10.
    drive_cycle("sw_timeout", 1'b0, 6'b111110, 1'b1, ST_FETCH);
    drive_cycle("sw_timeout", 1'b0, 6'b111110, 1'b0, ST_DECODE);
    drive_cycle("sw_timeout", 1'b0, 6'b111110, 1'b0, ST_MEM_ADDR);
    for (int i = 0; i < TMO + 1; i++)
      drive_cycle("sw_timeout", 1'b0, 6'b111110, 1'b0, ST_MEM_WR);
    drive_cycle("sw_timeout", 1'b0, 6'b111110, 1'b1, ST_TRAP_MEM);
    drive_cycle("sw_timeout", 1'b0, 6'b111110, 1'b0, ST_TRAP_MEM);
    drive_cycle("trap_reset", 1'b1, 6'b111110, 1'b0, ST_FETCH);

    // Instruction fetch that never completes also times out.
    for (int i = 0; i < TMO + 1; i++)
      drive_cycle("fetch_timeout", 1'b0, 6'b000000, 1'b0, ST_FETCH);
    drive_cycle("fetch_timeout", 1'b0, 6'b000000, 1'b1, ST_TRAP_MEM);
    drive_cycle("trap_reset",    1'b1, 6'b000000, 1'b1, ST_FETCH);
    drive_cycle("after_trap",    1'b0, 6'b000011, 1'b1, ST_FETCH);
    drive_cycle("after_trap",    1'b0, 6'b000011, 1'b1, ST_DECODE);
    drive_cycle("after_trap",    1'b0, 6'b000011, 1'b0, ST_JAL);
`else
    // Without traps a store may stall far past TMO and still complete.
    drive_cycle("after_rst", 1'b0, 6'b111110, 1'b1, ST_MEM_ADDR);
    for (int i = 0; i < TMO + 10; i++)
      drive_cycle("sw_stall", 1'b0, 6'b111110, 1'b0, ST_MEM_WR);
    drive_cycle("sw_stall", 1'b0, 6'b111110, 1'b1, ST_MEM_WR);
    drive_cycle("sw_stall", 1'b0, 6'b101100, 1'b1, ST_FETCH);
    drive_cycle("sw_stall", 1'b0, 6'b101100, 1'b1, ST_DECODE);
    drive_cycle("sw_stall", 1'b0, 6'b101100, 1'b0, ST_FETCH);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
